// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide valid/ready input, small FIFO, and a UART serialiser
// producing 8N1 frames (8E1 when the UART_TX_PARITY_EN macro is defined).
// The serial line idles high and is driven from a flop.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int PW           = $clog2(FIFO_DEPTH);
    localparam int CNTW         = PW + 1;
    localparam logic [CW-1:0]   BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wrPtr_q;
    logic [PW-1:0]   rdPtr_q;
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    // Serialiser state
    state_t          state_q;
    logic [CW-1:0]   baudCnt_q;
    logic [2:0]      bitIdx_q;
    logic            stopIdx_q;
    logic [7:0]      shift_q;
    logic            txLine_q;
`ifdef UART_TX_PARITY_EN
    logic            parity_q;
`endif

    logic            full;
    logic            push;
    logic            pop;
    logic            bitEnd;
    logic            stopLast;
    logic [7:0]      head;

    assign full     = (count_q == FULL_CNT);
    assign tx_ready = !full;
    assign push     = tx_valid && !full;
    assign head     = mem_q[rdPtr_q];
    assign bitEnd   = (baudCnt_q == BIT_LAST);
    assign stopLast = (STOP_BITS == 1) ? 1'b1 : stopIdx_q;

    // A byte leaves the FIFO when the line is idle, or when the last stop bit
    // of the current frame ends, so frames run back to back with no gap.
    assign pop = (count_q != '0) &&
                 ((state_q == IDLE) || ((state_q == STOP) && bitEnd && stopLast));

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNTW'(1);
        end
    end

    // FIFO write side, read pointer and occupancy; reset flushes everything.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= tx_data;
                wrPtr_q        <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Frame sequencer: every state lasts whole bit times counted by baudCnt_q,
    // and the line value for the next bit is registered on the transition.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            stopIdx_q <= 1'b0;
            shift_q   <= 8'h00;
            txLine_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    txLine_q  <= 1'b1;
                    baudCnt_q <= '0;
                    if (pop) begin
                        shift_q  <= head;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^head;
`endif
                        state_q  <= START;
                        txLine_q <= 1'b0;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        baudCnt_q <= '0;
                        bitIdx_q  <= '0;
                        state_q   <= DATA;
                        txLine_q  <= shift_q[0];
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bitEnd) begin
                        baudCnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q   <= PARITY;
                            txLine_q  <= parity_q;
`else
                            state_q   <= STOP;
                            stopIdx_q <= 1'b0;
                            txLine_q  <= 1'b1;
`endif
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                            shift_q  <= {1'b0, shift_q[7:1]};
                            txLine_q <= shift_q[1];
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bitEnd) begin
                        baudCnt_q <= '0;
                        state_q   <= STOP;
                        stopIdx_q <= 1'b0;
                        txLine_q  <= 1'b1;
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bitEnd) begin
                        baudCnt_q <= '0;
                        if (stopLast) begin
                            if (pop) begin
                                shift_q  <= head;
`ifdef UART_TX_PARITY_EN
                                parity_q <= ^head;
`endif
                                state_q  <= START;
                                txLine_q <= 1'b0;
                            end else begin
                                state_q  <= IDLE;
                                txLine_q <= 1'b1;
                            end
                        end else begin
                            stopIdx_q <= 1'b1;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    baudCnt_q <= '0;
                    txLine_q  <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx    = txLine_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter, the transmit-side companion of the existing UART receiver on the Tang Nano 4K board. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them as 8N1 frames (optionally 8E1) on the uart_tx pin. Intended clock is sys_clk at 27 MHz. Software-visible use: echo received bytes and send status text.

Parameters:
CLK_HZ, 27000000, sys_clk frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ / BAUD (integer division, 234 at defaults); must be >= 2
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2
STOP_BITS, 1, stop bit count; legal values 1 or 2

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous reset, active low
tx_data  input  8  byte to send
tx_valid  input  1  tx_data is valid this cycle
tx_ready  output  1  FIFO can accept a byte; equals !full, combinational from FIFO state only
uart_tx  output  1  serial line, idle high, registered
busy  output  1  high while FIFO non-empty or a frame is on the line
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes held in FIFO, excluding the frame in flight

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset is asynchronous and active-low on rst_n; every flop clears immediately on negedge rst_n.
- Reset values: uart_tx=1, busy=0, fifo_count=0, tx_ready=1, FSM=IDLE, FIFO pointers=0, baud counter=0.
- Push: on an edge with tx_valid && tx_ready, tx_data is written at the write pointer. When full, tx_ready=0 and tx_valid is ignored, even if a pop occurs on the same edge. A push on the same edge as a pop leaves fifo_count unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP.
- IDLE: uart_tx=1. If the FIFO is non-empty, on the next edge:
  - pop the head into an 8-bit shift register;
  - go to START, with uart_tx=0 and the baud counter at 0.
- Latency: a byte pushed into an empty FIFO while IDLE at edge N drives uart_tx low at edge N+1.
- Each bit lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1; the state advances when it reaches CLKS_PER_BIT-1.
- START: after one bit time, go to DATA with uart_tx = shift[0].
- DATA: sends 8 bits LSB first. A 3-bit bit index shifts after each bit time. After bit 7:
  - go to PARITY if the feature is compiled in;
  - otherwise go to STOP with uart_tx=1.
- STOP: holds uart_tx=1 for STOP_BITS bit times. At the end:
  - if the FIFO is non-empty, pop and go directly to START with uart_tx=0, with zero idle cycles between frames;
  - otherwise go to IDLE.
- Frame length: (10 + STOP_BITS - 1) × CLKS_PER_BIT cycles (+1 bit time with parity).
- busy = (state != IDLE) || (fifo_count != 0), registered-consistent with state; never glitches between back-to-back frames.
- tx_data is captured at push; later changes to tx_data do not affect queued bytes.
- Reset mid-frame: the line returns high at once, the frame is truncated, and the FIFO is flushed. No partial frame resumes after reset.

Optional Feature:
UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and sends one bit time of even parity (XOR of the 8 data bits) before STOP; format 8E1.
- Undefined: no PARITY state, format 8N1, no parity logic synthesised.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, release -> uart_tx=1, tx_ready=1, busy=0, fifo_count=0; uart_tx stays 1 for 100 cycles with no push.
- Single byte, CLK_HZ=1000, BAUD=100 (10 clks/bit): push 0x55 at edge N.
  - uart_tx falls at N+1, then bits 0,1,0,1,0,1,0,1,0 then 1 (start, data, stop), each 10 cycles;
  - busy drops at N+101.
- Back-to-back: push 0xA5 and 0x3C on consecutive cycles.
  - two 100-cycle frames with no idle gap: the stop of frame 1 is followed immediately by the start of frame 2;
  - decoded bytes are 0xA5 then 0x3C.
- Full FIFO: hold tx_valid=1 with bytes 0x01..0x06.
  - 0x01 is popped and 0x02..0x05 fill the FIFO, so fifo_count=4 and tx_ready=0;
  - 0x06 is accepted only on the edge after 0x01's frame ends and 0x02 is popped;
  - all six bytes arrive in order.
- Reset mid-frame: assert rst_n=0 during the DATA bits of 0xF0 -> uart_tx=1 within the same cycle, fifo_count=0, no further frames after release.
- With UART_TX_PARITY_EN: send 0x07 -> 11-bit frame; parity bit=1 (three ones); frame length 110 cycles at 10 clks/bit.
